// File: rtl/ingress_int_ctrl.sv
// ingress_int_ctrl: ingress interrupt controller.
// Captures rising edges on NUM_SRC event sources into sticky STATUS bits,
// masks them per source and drives one level interrupt. After the interrupt
// drops, a programmable holdoff window keeps it low to limit interrupt storms.
// Registers are reached over a simple one-cycle config port with a two-edge
// read pipeline.
// Optional feature: define INGRESS_INT_COUNT_EN to build the saturating
// INT_COUNT register at address 4. Without it, address 4 reads 0.
module ingress_int_ctrl #(
  parameter int NUM_SRC     = 16,
  parameter int HOLDOFF_W   = 8,
  parameter int HOLDOFF_RST = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] src_event,
  input  logic               cfg_wr_en,
  input  logic               cfg_rd_en,
  input  logic [2:0]         cfg_addr,
  input  logic [NUM_SRC-1:0] cfg_wdata,
  output logic [NUM_SRC-1:0] cfg_rdata,
  output logic               cfg_rd_valid,
  output logic               ingress_int_wire
);

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_MASK    = 3'd1;
  localparam logic [2:0] ADDR_HOLDOFF = 3'd2;
  localparam logic [2:0] ADDR_FORCE   = 3'd3;
  localparam logic [2:0] ADDR_COUNT   = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ASSERT,
    ST_HOLD
  } state_t;

  logic [NUM_SRC-1:0]   src_q;
  logic [NUM_SRC-1:0]   status_q;
  logic [NUM_SRC-1:0]   mask_q;
  logic [HOLDOFF_W-1:0] holdoff_q;
  logic [HOLDOFF_W-1:0] hold_cnt_q;
  logic [HOLDOFF_W-1:0] hold_cnt_d;
  state_t               state_q;
  state_t               state_d;

  logic [NUM_SRC-1:0]   rise;
  logic [NUM_SRC-1:0]   w1c;
  logic [NUM_SRC-1:0]   force_set;
  logic [NUM_SRC-1:0]   rd_word;
  logic [NUM_SRC-1:0]   count_rd;
  logic [NUM_SRC-1:0]   rd_stage_q;
  logic                 rd_stage_vld_q;
  logic                 pending;
  logic                 wr_status;
  logic                 wr_mask;
  logic                 wr_holdoff;
  logic                 wr_force;

  assign wr_status  = cfg_wr_en && (cfg_addr == ADDR_STATUS);
  assign wr_mask    = cfg_wr_en && (cfg_addr == ADDR_MASK);
  assign wr_holdoff = cfg_wr_en && (cfg_addr == ADDR_HOLDOFF);
  assign wr_force   = cfg_wr_en && (cfg_addr == ADDR_FORCE);

  assign rise      = src_event & ~src_q;
  assign w1c       = wr_status ? cfg_wdata : '0;
  assign force_set = wr_force ? cfg_wdata : '0;

  // MASK only gates the interrupt; capture into STATUS is never masked.
  assign pending = |(status_q & ~mask_q);

  assign ingress_int_wire = (state_q == ST_ASSERT);

  // Edge history, sticky STATUS (a set beats a same-cycle W1C), MASK and HOLDOFF.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      src_q     <= '0;
      status_q  <= '0;
      mask_q    <= '1;
      holdoff_q <= HOLDOFF_W'(HOLDOFF_RST);
    end else begin
      // NOTE: non-blocking assignments make every register see pre-edge values, independent of statement order.
      src_q    <= src_event;
      status_q <= (status_q & ~w1c) | rise | force_set;
      if (wr_mask)    mask_q    <= cfg_wdata;
      if (wr_holdoff) holdoff_q <= HOLDOFF_W'(cfg_wdata);
    end
  end

  // Interrupt FSM next-state: assert on pending, then sit out the holdoff window.
  always_comb begin
    // NOTE: defaults first so every path assigns state_d and hold_cnt_d and no latch is inferred.
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pending) state_d = ST_ASSERT;
      end
      ST_ASSERT: begin
        if (!pending) begin
          hold_cnt_d = holdoff_q;
          state_d    = (holdoff_q == '0) ? ST_IDLE : ST_HOLD;
        end
      end
      ST_HOLD: begin
        // pending is deliberately ignored until the window expires
        if (hold_cnt_q == HOLDOFF_W'(1)) state_d = ST_IDLE;
        else                             hold_cnt_d = hold_cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Interrupt FSM state and holdoff counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

`ifdef INGRESS_INT_COUNT_EN
  logic [15:0] int_count_q;
  logic        wr_count;

  assign wr_count = cfg_wr_en && (cfg_addr == ADDR_COUNT);
  assign count_rd = NUM_SRC'(int_count_q);

  // Saturating count of IDLE->ASSERT transitions; a write clears it and beats an increment.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      int_count_q <= '0;
    end else if (wr_count) begin
      int_count_q <= '0;
    end else if ((state_q == ST_IDLE) && (state_d == ST_ASSERT) && (int_count_q != 16'hFFFF)) begin
      int_count_q <= int_count_q + 16'd1;
    end
  end
`else
  assign count_rd = '0;
`endif

  // Read mux on registered state; FORCE and reserved addresses read as zero.
  always_comb begin
    rd_word = '0;
    case (cfg_addr)
      ADDR_STATUS:  rd_word = status_q;
      ADDR_MASK:    rd_word = mask_q;
      ADDR_HOLDOFF: rd_word = NUM_SRC'(holdoff_q);
      ADDR_COUNT:   rd_word = count_rd;
      default:      rd_word = '0;
    endcase
  end

  // Read pipeline: capture at the rd_en edge (so a same-cycle write is not seen), present one edge later.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_stage_vld_q <= 1'b0;
      rd_stage_q     <= '0;
      cfg_rd_valid   <= 1'b0;
      cfg_rdata      <= '0;
    end else begin
      rd_stage_vld_q <= cfg_rd_en;
      cfg_rd_valid   <= rd_stage_vld_q;
      if (cfg_rd_en)      rd_stage_q <= rd_word;
      if (rd_stage_vld_q) cfg_rdata  <= rd_stage_q;
    end
  end

endmodule
